// File: rtl/lisnoc_packet_injector_prio.sv
// rtl/lisnoc_packet_injector_prio.sv - source packetizer emitting priority-tagged HEADER/PAYLOAD/LAST or SINGLE flits
// Optional macro LISNOC_INJ_PRIO_ESCALATE_EN: escalate header priority while the header is stalled.
module lisnoc_packet_injector_prio #(
  parameter int flit_data_width = 32,
  parameter int flit_type_width = 2,
  parameter int ph_prio_width   = 4,
  parameter int ph_prio_offset  = 0,
  parameter int ph_dest_width   = 5,
  parameter int len_width       = 8
`ifdef LISNOC_INJ_PRIO_ESCALATE_EN
  ,
  parameter int stall_limit     = 16
`endif
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       cmd_valid_i,
  output logic                                       cmd_ready_o,
  input  logic [ph_dest_width-1:0]                   cmd_dest_i,
  input  logic [$clog2(ph_prio_width+1)-1:0]         cmd_prio_i,
  input  logic [len_width-1:0]                       cmd_len_i,
  input  logic                                       data_valid_i,
  output logic                                       data_ready_o,
  input  logic [flit_data_width-1:0]                 data_i,
  output logic [flit_type_width+flit_data_width-1:0] flit_o,
  output logic                                       valid_o,
  input  logic                                       ready_i
);

  localparam int FLIT_W   = flit_type_width + flit_data_width;
  localparam int PRIO_TOP = flit_data_width - ph_prio_offset - 1;

  localparam logic [flit_type_width-1:0] TYPE_PAYLOAD = flit_type_width'(0);
  localparam logic [flit_type_width-1:0] TYPE_HEADER  = flit_type_width'(1);
  localparam logic [flit_type_width-1:0] TYPE_LAST    = flit_type_width'(2);
  localparam logic [flit_type_width-1:0] TYPE_SINGLE  = flit_type_width'(3);

  typedef enum logic [1:0] {
    IDLE,
    HEAD,
    BODY
  } state_t;

  state_t                     state_q, state_d;
  logic [FLIT_W-1:0]          flit_q, flit_d;
  logic                       valid_q, valid_d;
  logic [len_width-1:0]       remaining_q, remaining_d;
  logic [ph_prio_width-1:0]   prio_field;
  logic [flit_data_width-1:0] hdr_data;

`ifdef LISNOC_INJ_PRIO_ESCALATE_EN
  localparam int STALL_W = $clog2(stall_limit + 1);
  localparam logic [ph_prio_width-1:0] PRIO_MSB = ph_prio_width'(1) << (ph_prio_width - 1);
  logic [STALL_W-1:0] stall_q, stall_d;
`endif

  // Thermometer code from the field MSB; levels above the width saturate to all-ones.
  always_comb begin
    prio_field = '0;
    for (int i = 0; i < ph_prio_width; i++) begin
      prio_field[ph_prio_width-1-i] = (int'(cmd_prio_i) > i);
    end
    hdr_data = '0;
    hdr_data[PRIO_TOP -: ph_prio_width] = prio_field;
    hdr_data[ph_dest_width-1:0] = cmd_dest_i;
  end

  // remaining_q counts payload words not yet loaded; the header drain cycle may already load the first one.
  assign data_ready_o = (state_q != IDLE) && (remaining_q != '0) && (!valid_q || ready_i);
  assign flit_o       = flit_q;
  assign valid_o      = valid_q;

  always_comb begin
    state_d     = state_q;
    flit_d      = flit_q;
    valid_d     = valid_q;
    remaining_d = remaining_q;
    cmd_ready_o = 1'b0;
`ifdef LISNOC_INJ_PRIO_ESCALATE_EN
    stall_d     = '0;
`endif
    case (state_q)
      IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) begin
          flit_d      = {(cmd_len_i == '0) ? TYPE_SINGLE : TYPE_HEADER, hdr_data};
          valid_d     = 1'b1;
          remaining_d = cmd_len_i;
          state_d     = HEAD;
        end
      end
      HEAD: begin
        if (ready_i) begin
          valid_d = 1'b0;
          state_d = (remaining_q == '0) ? IDLE : BODY;
        end
`ifdef LISNOC_INJ_PRIO_ESCALATE_EN
        else if (stall_q == STALL_W'(stall_limit - 1)) begin
          flit_d[PRIO_TOP -: ph_prio_width] = (flit_q[PRIO_TOP -: ph_prio_width] >> 1) | PRIO_MSB;
        end else begin
          stall_d = stall_q + STALL_W'(1);
        end
`endif
      end
      BODY: begin
        if (valid_q && ready_i) begin
          valid_d = 1'b0;
          if (remaining_q == '0) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (data_ready_o && data_valid_i) begin
      flit_d      = {(remaining_q == len_width'(1)) ? TYPE_LAST : TYPE_PAYLOAD, data_i};
      valid_d     = 1'b1;
      remaining_d = remaining_q - len_width'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      flit_q      <= '0;
      valid_q     <= 1'b0;
      remaining_q <= '0;
`ifdef LISNOC_INJ_PRIO_ESCALATE_EN
      stall_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      flit_q      <= flit_d;
      valid_q     <= valid_d;
      remaining_q <= remaining_d;
`ifdef LISNOC_INJ_PRIO_ESCALATE_EN
      stall_q     <= stall_d;
`endif
    end
  end

endmodule
